dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
// - Shares one single-port 32x32 data memory between two requesters (0: CPU load/store, 1: DMA/debug).
// - Round-robin arbitration, request/grant handshake, sequences one memory access at a time.
// - Returns read data or write acknowledge to the winning requester.
// - Sits between the requesters and the data memory port (address, write data, write/read strobes, read data).
// PARAMETERS
// - DEPTH   32  memory words; legal addresses 0..DEPTH-1
// - ADDR_W  5   forwarded address bits, clog2(DEPTH)
// - DATA_W  32  data width
// PORTS
// - clock       in   1         clock, all state on rising edge
// - reset       in   1         reset, synchronous, active-high
// - req         in   2         per-requester access request, held until granted
// - req_we      in   2         1 = write, 0 = read; per requester
// - req_addr    in   2*32      word address; requester i in bits [32*i +: 32]
// - req_wdata   in   2*DATA_W  write data; requester i in bits [DATA_W*i +: DATA_W]
// - gnt         out  2         one-hot, one-cycle accept pulse
// - resp_valid  out  1         one-cycle completion pulse
// - resp_id     out  1         requester the response belongs to
// - resp_rdata  out  DATA_W    read data; 0 for writes
// - resp_err    out  1         out-of-range access (feature macro only)
// - mem_addr    out  ADDR_W    to memory address
// - mem_wdata   out  DATA_W    to memory write data
// - mem_write   out  1         memory write strobe
// - mem_read    out  1         memory read strobe
// - mem_rdata   in   DATA_W    memory read data, registered one cycle after mem_read
// BEHAVIOUR
// - FSM states: IDLE -> ACCESS -> (read: RDWAIT) -> RESP -> IDLE.
// - IDLE: gnt combinational = winner of req, so gnt is high in the same cycle as req.
//   On that edge, latch id, we, addr, wdata and go to ACCESS. No requests: stay in IDLE.
// - Arbitration: one requester active -> it wins. Both active -> pointer wins.
//   After each grant, pointer = other id. Pointer resets to 0.
// - ACCESS: mem_write=latched we or mem_read=!we, high exactly one cycle.
//   mem_addr/mem_wdata hold the latched values during ACCESS.
//   Write -> RESP. Read -> RDWAIT.
// - RDWAIT: capture mem_rdata into resp_rdata -> RESP.
// - RESP: resp_valid=1 for one cycle, with resp_id and resp_rdata; next state IDLE.
// - Latency after a grant in cycle T: write strobe T+1, resp_valid T+2; read strobe T+1, resp_valid T+3.
// - Throughput: one access per 3 (write) or 4 (read) cycles.
// - No new gnt while busy; a requester dropping req before gnt is legal and causes no access.
// - Address arithmetic: mem_addr = latched addr[ADDR_W-1:0]; upper bits are ignored unless the macro is set.
// - Reset: state IDLE, pointer 0, and gnt, resp_valid, resp_id, resp_rdata, resp_err, mem_* all 0.
//   mem_write/mem_read are gated with !reset.
//   Reset mid-operation aborts the transaction: no response, and the write is suppressed if in ACCESS.
// CONFIGURATION
// - DMEM_ARB_BOUNDS_CHECK_EN defined:
//   addr >= DEPTH -> ACCESS issues no strobe; RESP with resp_err=1, resp_rdata=0; same latency as the request type.
// - Not defined: addresses wrap modulo DEPTH; resp_err tied 0.
// STRUCTURE
// - Package dmem_arb_pkg: state enum (IDLE, ACCESS, RDWAIT, RESP), DEPTH/ADDR_W/DATA_W defaults, request record typedef.
// - Sub-module rr_arbiter2: 2-way round-robin arbiter (req, pointer, advance -> one-hot gnt).
//   The FSM, latches and response path stay in dmem_arbiter.
// TESTING
// - Single write: req=01, we=1, addr=3, wdata=0xDEADBEEF -> gnt=01 at T, mem_write T+1 addr 3, resp_valid id0 T+2.
// - Read back: req=01, we=0, addr=3 -> mem_read T+1, resp_valid T+3, resp_rdata=0xDEADBEEF, id0.
// - Contention: req=11 from reset -> id0 first, then id1; repeat -> 0,1,0,1 alternation; both responses correct.
// - Hold during busy: id1 raises req during id0's ACCESS -> no gnt until IDLE; id1 is then granted next.
// - Reset mid-op: reset asserted in ACCESS of a write to addr 5 -> mem_write 0, no resp_valid, mem[5] unchanged, pointer 0.
// - Range: addr=40 write 0x1 -> macro on: resp_err=1, no strobe; macro off: mem[8] written, resp_err=0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and defaults for the data-memory arbiter.
//   state_t     - arbiter FSM states (IDLE, ACCESS, RDWAIT, RESP)
//   req_rec_t   - control fields of the request that won arbitration
//   DEPTH_DEF / ADDR_W_DEF / DATA_W_DEF - default memory geometry
//   REQ_ADDR_W  - width of each requester's address field on the bus
//   onehot_to_id - converts a 2-bit one-hot grant to a requester index
package dmem_arb_pkg;

  localparam int unsigned DEPTH_DEF  = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned REQ_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Write data is kept outside the record so DATA_W can be overridden
  // per instance without touching the package.
  typedef struct packed {
    logic                  id;
    logic                  we;
    logic [REQ_ADDR_W-1:0] addr;
  } req_rec_t;

  function automatic logic onehot_to_id(input logic [1:0] onehot);
    return onehot[1];
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter.
//   clock   in   clock, rising edge
//   reset   in   synchronous, active-high; pointer returns to requester 0
//   req     in   [1:0] pending requests
//   advance in   grant may be issued this cycle (owner is ready to accept)
//   gnt     out  [1:0] one-hot grant, combinational from req/pointer/advance
// A lone requester always wins. With both requesting, the pointer picks
// the winner; after every issued grant the pointer moves to the other side.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Winner 0 hands priority to 1 and vice versa, so ptr_d equals gnt[0].
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) begin
      ptr_d = gnt[0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between two requesters
// (0 = CPU load/store, 1 = DMA/debug), one access at a time.
//   clock / reset          clock and synchronous active-high reset
//   req, req_we            per-requester request (held until gnt) and write flag
//   req_addr, req_wdata    packed per-requester address (32b) and write data
//   gnt                    one-hot accept pulse, combinational in IDLE
//   resp_valid/id/rdata/err  one-cycle completion with owner and read data
//   mem_addr/wdata/write/read  memory port, driven only during ACCESS
//   mem_rdata              memory read data, valid one cycle after mem_read
// Sequence: IDLE -> ACCESS -> (reads: RDWAIT) -> RESP -> IDLE.
// Optional feature macro DMEM_ARB_BOUNDS_CHECK_EN: addresses >= DEPTH get
// no memory strobe and complete with resp_err=1. Without it addresses
// wrap modulo DEPTH and resp_err is tied 0.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [1:0]              req,
  input  logic [1:0]              req_we,
  input  logic [2*REQ_ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0]     req_wdata,
  output logic [1:0]              gnt,
  output logic                    resp_valid,
  output logic                    resp_id,
  output logic [DATA_W-1:0]       resp_rdata,
  output logic                    resp_err,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    mem_write,
  output logic                    mem_read,
  input  logic [DATA_W-1:0]       mem_rdata
);

  state_t            state_q, state_d;
  req_rec_t          rec_q, rec_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [REQ_ADDR_W-1:0] addr_arr  [2];
  logic [DATA_W-1:0]     wdata_arr [2];

  logic              win_id;
  logic              oob;
  logic              access_en;
  logic              resp_en;
  logic [ADDR_W-1:0] addr_wrap;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[REQ_ADDR_W*gi +: REQ_ADDR_W];
      assign wdata_arr[gi] = req_wdata[DATA_W*gi +: DATA_W];
    end
  endgenerate

  // Grants are only offered while IDLE and never during reset, so a
  // requester raising req while the FSM is busy simply waits.
  rr_arbiter2 u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (!reset && (state_q == IDLE)),
    .gnt     (gnt)
  );

  assign win_id = onehot_to_id(gnt);

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  assign oob = (rec_q.addr >= REQ_ADDR_W'(DEPTH));
`else
  assign oob = 1'b0;
`endif

  assign addr_wrap = ADDR_W'(rec_q.addr % REQ_ADDR_W'(DEPTH));

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          rec_d.id   = win_id;
          rec_d.we   = req_we[win_id];
          rec_d.addr = addr_arr[win_id];
          wdata_d    = wdata_arr[win_id];
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        // Cleared here so writes (and rejected reads) answer with zero.
        rdata_d = '0;
        state_d = rec_q.we ? RESP : RDWAIT;
      end
      RDWAIT: begin
        rdata_d = oob ? '0 : mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rec_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset gates the strobes combinationally so a write caught in ACCESS
  // when reset arrives never reaches the memory.
  assign access_en = !reset && (state_q == ACCESS);
  assign resp_en   = !reset && (state_q == RESP);

  assign mem_write = access_en &&  rec_q.we && !oob;
  assign mem_read  = access_en && !rec_q.we && !oob;
  assign mem_addr  = access_en ? addr_wrap : '0;
  assign mem_wdata = access_en ? wdata_q : '0;

  assign resp_valid = resp_en;
  assign resp_id    = resp_en && rec_q.id;
  assign resp_rdata = resp_en ? rdata_q : '0;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
  logic err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (state_q == ACCESS) begin
      err_q <= oob;
    end
  end

  assign resp_err = resp_en && err_q;
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized scoreboard bench for dmem_arbiter.
// The driver predicts grants from the arbitration rules and pushes the
// expected memory strobe and response for every grant; a monitor on the
// falling edge pops and compares whenever the DUT strobes or responds.
module tb_dmem_arbiter;

  localparam int DEPTH  = 32;
  localparam int DATA_W = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [1:0]  req_we = 2'b00;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [1:0]  gnt;
  logic        resp_valid;
  logic        resp_id;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [4:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata = '0;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_id    (resp_id),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  // Memory environment: registered read, loaded with a known pattern.
  logic [31:0] tb_mem [DEPTH];
  logic        mem_init = 1'b1;

  always @(posedge clock) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) tb_mem[i] <= init_word(i);
    end else begin
      if (mem_write) tb_mem[mem_addr] <= mem_wdata;
      if (mem_read)  mem_rdata <= tb_mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        id;
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } strb_t;

  resp_t resp_q[$];
  strb_t strb_q[$];

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: memory contents, who has priority, and the
  // first cycle the arbiter may grant again.
  logic [31:0] ref_mem [DEPTH];
  logic        ref_ptr = 1'b0;
  int          busy_until = 0;

  // Monitor
  always @(negedge clock) begin
    resp_t e;
    strb_t s;
    if (resp_valid) begin
      vectors++;
      if (resp_q.size() == 0) begin
        miscompares++;
        $display("FAIL resp_unexpected cyc=%0d got id=%0d rdata=%h err=%0d, required none",
                 cyc, resp_id, resp_rdata, resp_err);
      end else begin
        e = resp_q.pop_front();
        if (e.cyc != cyc || resp_id !== e.id || resp_rdata !== e.rdata || resp_err !== e.err) begin
          miscompares++;
          $display("FAIL resp got cyc=%0d id=%0d rdata=%h err=%0d, required cyc=%0d id=%0d rdata=%h err=%0d",
                   cyc, resp_id, resp_rdata, resp_err, e.cyc, e.id, e.rdata, e.err);
        end
      end
    end else if (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
      vectors++;
      miscompares++;
      e = resp_q.pop_front();
      $display("FAIL resp_missing at cyc=%0d, required id=%0d rdata=%h", cyc, e.id, e.rdata);
    end

    if (mem_write || mem_read) begin
      vectors++;
      if (strb_q.size() == 0) begin
        miscompares++;
        $display("FAIL strobe_unexpected cyc=%0d got write=%0d read=%0d addr=%0d, required none",
                 cyc, mem_write, mem_read, mem_addr);
      end else begin
        s = strb_q.pop_front();
        if (s.cyc != cyc || mem_write !== s.we || mem_read !== !s.we || mem_addr !== s.addr ||
            (s.we && mem_wdata !== s.wdata)) begin
          miscompares++;
          $display("FAIL strobe got cyc=%0d w=%0d r=%0d addr=%0d wdata=%h, required cyc=%0d we=%0d addr=%0d wdata=%h",
                   cyc, mem_write, mem_read, mem_addr, mem_wdata, s.cyc, s.we, s.addr, s.wdata);
        end
      end
    end else if (strb_q.size() > 0 && strb_q[0].cyc <= cyc) begin
      vectors++;
      miscompares++;
      s = strb_q.pop_front();
      $display("FAIL strobe_missing at cyc=%0d, required we=%0d addr=%0d", cyc, s.we, s.addr);
    end
  end

  // Called on the falling edge of the grant cycle g.
  task automatic expect_access(input logic id, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int   g;
    int   idx;
    logic oob;
    g   = cyc;
    idx = int'(addr % DEPTH);
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    oob = (addr >= DEPTH);
`else
    oob = 1'b0;
`endif
    if (!oob) strb_q.push_back('{cyc: g + 1, we: we, addr: 5'(idx), wdata: wdata});
    if (we) begin
      if (!oob) ref_mem[idx] = wdata;
      resp_q.push_back('{cyc: g + 2, id: id, rdata: 32'd0, err: oob});
      busy_until = g + 3;
    end else begin
      resp_q.push_back('{cyc: g + 3, id: id, rdata: (oob ? 32'd0 : ref_mem[idx]), err: oob});
      busy_until = g + 4;
    end
    ref_ptr = ~id;
  endtask

  // Raise the requests in r and hold each until granted.
  task automatic run(input logic [1:0] r, input logic [1:0] we,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1);
    logic [1:0] pending;
    logic [1:0] exp_gnt;
    logic       w;
    req_we    = we;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    pending   = r;
    req       = r;
    for (int k = 0; k < 40 && pending != 2'b00; k++) begin
      @(negedge clock);
      exp_gnt = 2'b00;
      w       = 1'b0;
      if (cyc >= busy_until) begin
        w       = (pending == 2'b11) ? ref_ptr : pending[1];
        exp_gnt = w ? 2'b10 : 2'b01;
      end
      vectors++;
      if (gnt !== exp_gnt) begin
        miscompares++;
        $display("FAIL gnt cyc=%0d got %b, required %b", cyc, gnt, exp_gnt);
        pending = 2'b00;
      end else if (exp_gnt != 2'b00) begin
        expect_access(w, we[w], w ? a1 : a0, w ? d1 : d0);
        pending[w] = 1'b0;
      end
      @(posedge clock);
      #1;
      req = pending;
    end
    if (pending != 2'b00) begin
      vectors++;
      miscompares++;
      $display("FAIL gnt_timeout pending=%b, required grant", pending);
      req = 2'b00;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      if (cyc >= busy_until && resp_q.size() == 0 && strb_q.size() == 0) break;
      @(posedge clock);
      #1;
    end
    vectors++;
    if (!(cyc >= busy_until && resp_q.size() == 0 && strb_q.size() == 0)) begin
      miscompares++;
      $display("FAIL drain got %0d resp / %0d strobes outstanding, required 0",
               resp_q.size(), strb_q.size());
    end
  endtask

  initial begin
    logic [1:0]  r;
    logic [1:0]  w;
    logic [31:0] a0, a1, d0, d1;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Reset: requests are ignored and every output stays low.
    reset = 1'b1;
    req   = 2'b11;
    repeat (3) @(posedge clock);
    @(negedge clock);
    vectors++;
    if ({gnt, resp_valid, resp_id, resp_rdata, resp_err, mem_addr, mem_wdata, mem_write, mem_read} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got gnt=%b rv=%0d mw=%0d mr=%0d addr=%0d, required all 0",
               gnt, resp_valid, mem_write, mem_read, mem_addr);
    end
    @(posedge clock);
    #1;
    reset      = 1'b0;
    mem_init   = 1'b0;
    req        = 2'b00;
    ref_ptr    = 1'b0;
    busy_until = cyc;

    // Single write, then read it back.
    run(2'b01, 2'b01, 32'd3, 32'd0, 32'hDEAD_BEEF, 32'd0);
    run(2'b01, 2'b00, 32'd3, 32'd0, 32'd0, 32'd0);

    // Contention: both held, alternation, second side waits out the busy window.
    for (int i = 0; i < 4; i++) begin
      run(2'b11, 2'($urandom_range(0, 3)), 32'($urandom_range(0, 31)), 32'($urandom_range(0, 31)),
          $urandom, $urandom);
    end

    // Reset during ACCESS of a write to address 5.
    drain();
    req_we    = 2'b01;
    req_addr  = {32'd0, 32'd5};
    req_wdata = {32'd0, 32'hBAD0_BAD0};
    req       = 2'b01;
    @(negedge clock);
    vectors++;
    if (gnt !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_gnt got %b, required 01", gnt);
    end
    @(posedge clock);
    #1;
    req   = 2'b00;
    reset = 1'b1;
    @(negedge clock);
    vectors++;
    if ({mem_write, mem_read, resp_valid, gnt} !== 5'b0) begin
      miscompares++;
      $display("FAIL rst_abort got mw=%0d mr=%0d rv=%0d gnt=%b, required all 0",
               mem_write, mem_read, resp_valid, gnt);
    end
    @(posedge clock);
    #1;
    reset      = 1'b0;
    ref_ptr    = 1'b0;
    busy_until = cyc;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    vectors++;
    if (tb_mem[5] !== ref_mem[5]) begin
      miscompares++;
      $display("FAIL rst_mem5 got %h, required %h", tb_mem[5], ref_mem[5]);
    end
    run(2'b01, 2'b00, 32'd5, 32'd0, 32'd0, 32'd0);
    run(2'b11, 2'b11, 32'd10, 32'd11, 32'h1111_0000, 32'h2222_0000);
    run(2'b11, 2'b00, 32'd10, 32'd11, 32'd0, 32'd0);

    // Out-of-range address.
    run(2'b01, 2'b01, 32'd40, 32'd0, 32'h0000_0001, 32'd0);
    run(2'b10, 2'b00, 32'd0, 32'd40, 32'd0, 32'd0);
    run(2'b01, 2'b00, 32'd8, 32'd0, 32'd0, 32'd0);

    // Randomized traffic with idle gaps.
    for (int i = 0; i < 40; i++) begin
      r  = 2'($urandom_range(1, 3));
      w  = 2'($urandom_range(0, 3));
      a0 = 32'($urandom_range(0, 63));
      a1 = 32'($urandom_range(0, 63));
      d0 = $urandom;
      d1 = $urandom;
      run(r, w, a0, a1, d0, d1);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clock);
        #1;
      end
    end

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
